// File: rtl/aes_ced_pkg.sv
// aes_ced_pkg
//   Shared types and constants for the AES round sequencer with concurrent
//   error detection (CED).
//   - ced_mode_e  : latched CED scheduling mode
//   - seq_state_e : sequencer FSM states
//   - SEL_*       : dp_sel encodings driven to the round datapath
//   - decode_mode : maps the raw 2-bit mode input, 2'b11 folds to CED_OFF
package aes_ced_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    CED_OFF  = 2'd0,
    CED_FULL = 2'd1,
    CED_SEL  = 2'd2
  } ced_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRIM = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] SEL_INIT  = 2'd0;
  localparam logic [1:0] SEL_MID   = 2'd1;
  localparam logic [1:0] SEL_FINAL = 2'd2;

  function automatic ced_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return CED_FULL;
      2'b10:   return CED_SEL;
      default: return CED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/aes_ced_round_sequencer_pass_timer.sv
// ced_pass_timer
//   Counts the cycles of one datapath pass, 0..PASS_CYCLES-1, and flags the
//   final cycle. Wraps to 0 on the final cycle so back-to-back passes need
//   no extra clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : advance the count
//   last     : high on the final cycle of a pass while enabled
module ced_pass_timer #(
  parameter int PASS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [3:0] cnt;

  assign last = en && (cnt == 4'(PASS_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/aes_ced_round_sequencer.sv
// aes_ced_round_sequencer
//   Steps the AES round datapath through rounds 0..NUM_ROUNDS, inserting a
//   redundant alpha-permuted check pass after the primary pass of selected
//   rounds, and records the first round whose check disagreed.
//   Optional build macro: CED_ABORT_ON_FAULT_EN -- the first mismatch ends the
//   run; DONE follows the faulting check pass immediately.
//   Inputs : clk, rst, start, abort, ced_mode, ced_round, cmp_mismatch
//   Outputs: busy, done, round_idx, dp_sel, dp_perm, dp_load,
//            fault_detected, fault_location
//
//   state | meaning
//   IDLE  | waiting for start
//   PRIM  | primary pass of round round_q
//   CHK   | permuted check pass of round round_q
//   DONE  | one-cycle completion pulse
module aes_ced_round_sequencer
  import aes_ced_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES_NUM_ROUNDS,
  parameter int PASS_CYCLES = 2,
  parameter int RIDX_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        ced_mode,
  input  logic [RIDX_W-1:0] ced_round,
  input  logic              cmp_mismatch,
  output logic              busy,
  output logic              done,
  output logic [RIDX_W-1:0] round_idx,
  output logic [1:0]        dp_sel,
  output logic              dp_perm,
  output logic              dp_load,
  output logic              fault_detected,
  output logic [RIDX_W-1:0] fault_location
);

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS);

  seq_state_e        state_q, state_d;
  ced_mode_e         mode_q, mode_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [RIDX_W-1:0] sel_round_q, sel_round_d;
  logic [RIDX_W-1:0] loc_q, loc_d;
  logic              fault_q, fault_d;
  logic              active, pass_last, check_here, new_fault, end_on_fault;

  assign active = (state_q == PRIM) || (state_q == CHK);

  ced_pass_timer #(.PASS_CYCLES(PASS_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!active || abort),
    .en   (active),
    .last (pass_last)
  );

  // An out-of-range selected round never matches, so no check pass runs.
  assign check_here = (mode_q == CED_FULL) ||
                      ((mode_q == CED_SEL) && (round_q == sel_round_q));

  assign new_fault = (state_q == CHK) && pass_last && cmp_mismatch && !fault_q;

`ifdef CED_ABORT_ON_FAULT_EN
  assign end_on_fault = new_fault;
`else
  assign end_on_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    round_d     = round_q;
    sel_round_d = sel_round_q;
    fault_d     = fault_q;
    loc_d       = loc_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = PRIM;
          mode_d      = decode_mode(ced_mode);
          round_d     = '0;
          sel_round_d = ced_round;
          fault_d     = 1'b0;
          loc_d       = '0;
        end
      end
      PRIM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pass_last) begin
          if (check_here) begin
            state_d = CHK;
          end else if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RIDX_W'(1);
          end
        end
      end
      CHK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pass_last) begin
          if (new_fault) begin
            fault_d = 1'b1;
            loc_d   = round_q;
          end
          if ((round_q == LAST_ROUND) || end_on_fault) begin
            state_d = DONE;
          end else begin
            state_d = PRIM;
            round_d = round_q + RIDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= CED_OFF;
      round_q     <= '0;
      sel_round_q <= '0;
      fault_q     <= 1'b0;
      loc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      round_q     <= round_d;
      sel_round_q <= sel_round_d;
      fault_q     <= fault_d;
      loc_q       <= loc_d;
    end
  end

  // Round index and select are only meaningful while a pass is running.
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign round_idx      = active ? round_q : '0;
  assign dp_sel         = !active                  ? SEL_INIT  :
                          (round_q == '0)          ? SEL_INIT  :
                          (round_q == LAST_ROUND)  ? SEL_FINAL : SEL_MID;
  assign dp_perm        = (state_q == CHK);
  assign dp_load        = pass_last;
  assign fault_detected = fault_q;
  assign fault_location = loc_q;

endmodule
